// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - two-client round-robin arbiter for a 1W/1R register file with clear-on-reset
module rf_port_arbiter #(
   parameter logic [7:0] INIT_VAL = 8'h00,
   parameter bit         DO_INIT  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_req_0,
   input  logic [2:0] wr_addr_0,
   input  logic [7:0] wr_data_0,
   output logic       wr_gnt_0,
   input  logic       wr_req_1,
   input  logic [2:0] wr_addr_1,
   input  logic [7:0] wr_data_1,
   output logic       wr_gnt_1,
   input  logic       rd_req_0,
   input  logic [2:0] rd_addr_0,
   output logic       rd_gnt_0,
   output logic       rd_vld_0,
   output logic [7:0] rd_data_0,
   input  logic       rd_req_1,
   input  logic [2:0] rd_addr_1,
   output logic       rd_gnt_1,
   output logic       rd_vld_1,
   output logic [7:0] rd_data_1,
   output logic       rf_we,
   output logic [2:0] rf_write_addr,
   output logic [7:0] rf_data,
   output logic [2:0] rf_read_addr,
   input  logic [7:0] rf_q,
   output logic       init_busy
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt;
   logic       wr_prio, rd_prio;
   logic       vld0_q, vld1_q;
   logic       fwd_q, rd_fwd;
   logic [7:0] fwd_data_q;
   logic [7:0] hold0_q, hold1_q;
   logic [7:0] rd_src;

   always_comb begin
      state_nxt     = state;
      wr_gnt_0      = 1'b0;
      wr_gnt_1      = 1'b0;
      rd_gnt_0      = 1'b0;
      rd_gnt_1      = 1'b0;
      rf_we         = 1'b0;
      rf_write_addr = 3'd0;
      rf_data       = 8'h00;
      rf_read_addr  = 3'd0;
      init_busy     = 1'b0;
      rd_fwd        = 1'b0;
      if (reset) begin
         init_busy = DO_INIT;
      end else begin
         case (state)
            ST_INIT: begin
               rf_we         = 1'b1;
               rf_write_addr = cnt;
               rf_data       = INIT_VAL;
               init_busy     = 1'b1;
               if (cnt == 3'd7)
                  state_nxt = ST_RUN;
            end
            default: begin
               // prio bit names the client that wins a tie
               wr_gnt_0 = wr_req_0 & (~wr_req_1 | ~wr_prio);
               wr_gnt_1 = wr_req_1 & (~wr_req_0 |  wr_prio);
               rd_gnt_0 = rd_req_0 & (~rd_req_1 | ~rd_prio);
               rd_gnt_1 = rd_req_1 & (~rd_req_0 |  rd_prio);
               rf_we    = wr_gnt_0 | wr_gnt_1;
               if (wr_gnt_1) begin
                  rf_write_addr = wr_addr_1;
                  rf_data       = wr_data_1;
               end else if (wr_gnt_0) begin
                  rf_write_addr = wr_addr_0;
                  rf_data       = wr_data_0;
               end
               if (rd_gnt_1)
                  rf_read_addr = rd_addr_1;
               else if (rd_gnt_0)
                  rf_read_addr = rd_addr_0;
               rd_fwd = rf_we & (rd_gnt_0 | rd_gnt_1) & (rf_write_addr == rf_read_addr);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= DO_INIT ? ST_INIT : ST_RUN;
         cnt        <= 3'd0;
         wr_prio    <= 1'b0;
         rd_prio    <= 1'b0;
         vld0_q     <= 1'b0;
         vld1_q     <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_data_q <= 8'h00;
         hold0_q    <= 8'h00;
         hold1_q    <= 8'h00;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT)
            cnt <= cnt + 3'd1;
         if (wr_gnt_0)
            wr_prio <= 1'b1;
         else if (wr_gnt_1)
            wr_prio <= 1'b0;
         if (rd_gnt_0)
            rd_prio <= 1'b1;
         else if (rd_gnt_1)
            rd_prio <= 1'b0;
         vld0_q     <= rd_gnt_0;
         vld1_q     <= rd_gnt_1;
         fwd_q      <= rd_fwd;
         fwd_data_q <= rf_data;
         if (rd_vld_0)
            hold0_q <= rd_data_0;
         if (rd_vld_1)
            hold1_q <= rd_data_1;
      end
   end

   // rf_q is the RAM's registered output, so the response is muxed in without another flop
   assign rd_src    = fwd_q ? fwd_data_q : rf_q;
   assign rd_vld_0  = vld0_q & ~reset;
   assign rd_vld_1  = vld1_q & ~reset;
   assign rd_data_0 = rd_vld_0 ? rd_src : hold0_q;
   assign rd_data_1 = rd_vld_1 ? rd_src : hold1_q;

endmodule
